// File: rtl/mapper_pkg.sv
// Shared decode constants and register-field helpers for the discrete-latch mapper family.
// Decode modes above DEC_M140 fall back to GxROM behaviour.
package mapper_pkg;

    localparam logic [2:0] DEC_GXROM   = 3'd0;
    localparam logic [2:0] DEC_CDREAMS = 3'd1;
    localparam logic [2:0] DEC_M38     = 3'd2;
    localparam logic [2:0] DEC_NINA    = 3'd3;
    localparam logic [2:0] DEC_M140    = 3'd4;

    localparam logic [15:0] DEC_PRG_MASK  = 16'h8000;
    localparam logic [15:0] DEC_PRG_VAL   = 16'h8000;
    localparam logic [15:0] DEC_M38_MASK  = 16'hF000;
    localparam logic [15:0] DEC_M38_VAL   = 16'h7000;
    localparam logic [15:0] DEC_NINA_MASK = 16'hE100;
    localparam logic [15:0] DEC_NINA_VAL  = 16'h4100;
    localparam logic [15:0] DEC_M140_MASK = 16'hE000;
    localparam logic [15:0] DEC_M140_VAL  = 16'h6000;

    localparam logic [7:0] SS_IDX_BANK = 8'd0;
    localparam logic [7:0] SS_IDX_PEND = 8'd1;
    localparam logic [7:0] SS_IDX_MAP  = 8'd127;

    typedef struct packed {
        logic [3:0] prg;
        logic [3:0] chr;
    } bank_t;

    function automatic logic [2:0] dec_norm(input logic [2:0] mode);
        return (mode > DEC_M140) ? DEC_GXROM : mode;
    endfunction

    function automatic logic dec_hit(input logic [2:0] mode, input logic [15:0] addr);
        logic hit;
        hit = 1'b0;
        case (dec_norm(mode))
            DEC_M38:  hit = (addr & DEC_M38_MASK)  == DEC_M38_VAL;
            DEC_NINA: hit = (addr & DEC_NINA_MASK) == DEC_NINA_VAL;
            DEC_M140: hit = (addr & DEC_M140_MASK) == DEC_M140_VAL;
            default:  hit = (addr & DEC_PRG_MASK)  == DEC_PRG_VAL;
        endcase
        return hit;
    endfunction

    // Full 4-bit fields; callers truncate to their configured bank widths.
    function automatic bank_t dec_fields(input logic [2:0] mode, input logic [7:0] d);
        bank_t b;
        b = '0;
        case (dec_norm(mode))
            DEC_CDREAMS: begin b.prg = {2'b00, d[1:0]}; b.chr = d[7:4];             end
            DEC_M38:     begin b.prg = {2'b00, d[1:0]}; b.chr = {2'b00, d[3:2]};    end
            DEC_NINA:    begin b.prg = {3'b000, d[3]};  b.chr = {d[6], d[2:0]};     end
            default:     begin b.prg = {2'b00, d[5:4]}; b.chr = d[3:0];             end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/map_dlatch_if.sv
// Cartridge-side bus bundle for map_dlatch: CPU/PPU buses, ROM/CIRAM outputs, save-state port.
// The master drives the buses (board/testbench); the slave is the mapper.
interface map_dlatch_if #(
    parameter int PRG_BW = 2,
    parameter int CHR_BW = 4
);
    logic                  m2;
    logic [15:0]           cpu_addr;
    logic [7:0]            cpu_dat;
    logic                  cpu_rw;
    logic [7:0]            rom_dat;
    logic [13:0]           ppu_addr;
    logic                  ss_act;
    logic                  ss_we;
    logic [7:0]            ss_addr;
    logic [7:0]            ss_rdat;
    logic [14+PRG_BW:0]    prg_addr;
    logic [12+CHR_BW:0]    chr_addr;
    logic                  ciram_a10;
    logic                  ciram_ce;
    logic                  rom_ce;

    modport master (
        output m2, cpu_addr, cpu_dat, cpu_rw, rom_dat, ppu_addr, ss_act, ss_we, ss_addr,
        input  ss_rdat, prg_addr, chr_addr, ciram_a10, ciram_ce, rom_ce
    );

    modport slave (
        input  m2, cpu_addr, cpu_dat, cpu_rw, rom_dat, ppu_addr, ss_act, ss_we, ss_addr,
        output ss_rdat, prg_addr, chr_addr, ciram_a10, ciram_ce, rom_ce
    );
endinterface

// File: rtl/m2_edge.sv
// Brings raw CPU M2 into the clk domain and flags its falling edge.
// o_m2_s lags M2 by two clocks; o_fall is a one-clock pulse in the cycle o_m2_s drops.
module m2_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_m2,
    output logic o_m2_s,
    output logic o_fall
);
    logic r_m2_meta;
    logic r_m2_s;
    logic r_m2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m2_meta <= 1'b0;
            r_m2_s    <= 1'b0;
            r_m2_q    <= 1'b0;
        end else begin
            r_m2_meta <= i_m2;
            r_m2_s    <= r_m2_meta;
            r_m2_q    <= r_m2_s;
        end
    end

    assign o_m2_s = r_m2_s;
    assign o_fall = r_m2_q & ~r_m2_s;
endmodule

// File: rtl/map_dlatch.sv
// Discrete-latch NROM-family mapper (GxROM, Color Dreams, 38, NINA-03/06, 140) with save-state access.
// A CPU write lands in the bank register 4 clk after the raw M2 fall (+/-1 clk of synchroniser skew).
module map_dlatch
    import mapper_pkg::*;
#(
    parameter int PRG_BW   = 2,
    parameter int CHR_BW   = 4,
    parameter int BUS_CONF = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_dec_mode,
    input  logic        i_cfg_mir_v,
    input  logic [7:0]  i_map_idx,
    map_dlatch_if.slave io_bus
);
    logic              w_m2_s;
    logic              w_fall;

    logic [3:0]        r_cap_hi;
    logic              r_cap_a8;
    logic [7:0]        r_cap_dat;
    logic [7:0]        r_cap_rom;
    logic              r_cap_rw;

    logic              r_pend;
    logic [PRG_BW-1:0] r_nxt_prg;
    logic [CHR_BW-1:0] r_nxt_chr;
    logic [PRG_BW-1:0] r_prg;
    logic [CHR_BW-1:0] r_chr;

    logic [15:0]       w_cap_addr;
    logic              w_hit;
    logic [7:0]        w_d;
    bank_t             w_fld;
    logic              w_ss_wr;
    logic [7:0]        w_ss_rdat;

    m2_edge u_m2_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_m2   (io_bus.m2),
        .o_m2_s (w_m2_s),
        .o_fall (w_fall)
    );

    // Only A15..A12 and A8 take part in any decode, so only those are captured.
    assign w_cap_addr = {r_cap_hi, 3'b000, r_cap_a8, 8'h00};
    assign w_hit      = dec_hit(i_dec_mode, w_cap_addr);
    assign w_d        = (BUS_CONF != 0 && r_cap_hi[3]) ? (r_cap_dat & r_cap_rom) : r_cap_dat;
    assign w_fld      = dec_fields(i_dec_mode, w_d);
    assign w_ss_wr    = io_bus.ss_act && io_bus.ss_we && (io_bus.ss_addr == SS_IDX_BANK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cap_hi  <= '0;
            r_cap_a8  <= 1'b0;
            r_cap_dat <= '0;
            r_cap_rom <= '0;
            r_cap_rw  <= 1'b0;
            r_pend    <= 1'b0;
            r_nxt_prg <= '0;
            r_nxt_chr <= '0;
            r_prg     <= '0;
            r_chr     <= '0;
        end else begin
            if (w_m2_s) begin
                r_cap_hi  <= io_bus.cpu_addr[15:12];
                r_cap_a8  <= io_bus.cpu_addr[8];
                r_cap_dat <= io_bus.cpu_dat;
                r_cap_rom <= io_bus.rom_dat;
                r_cap_rw  <= io_bus.cpu_rw;
            end

            // Save-state access owns the register: it overrides and discards any CPU write.
            if (io_bus.ss_act) begin
                r_pend <= 1'b0;
                if (w_ss_wr) begin
                    r_prg <= io_bus.cpu_dat[4 +: PRG_BW];
                    r_chr <= io_bus.cpu_dat[0 +: CHR_BW];
                end
            end else begin
                if (r_pend) begin
                    r_prg  <= r_nxt_prg;
                    r_chr  <= r_nxt_chr;
                    r_pend <= 1'b0;
                end
                if (w_fall && !r_cap_rw && w_hit) begin
                    r_pend    <= 1'b1;
                    r_nxt_prg <= w_fld.prg[PRG_BW-1:0];
                    r_nxt_chr <= w_fld.chr[CHR_BW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_ss_rdat = 8'hFF;
        case (io_bus.ss_addr)
            SS_IDX_BANK: w_ss_rdat = {4'(r_prg), 4'(r_chr)};
            SS_IDX_PEND: w_ss_rdat = {7'd0, r_pend};
            SS_IDX_MAP:  w_ss_rdat = i_map_idx;
            default:     w_ss_rdat = 8'hFF;
        endcase
    end

    assign io_bus.ss_rdat   = w_ss_rdat;
    assign io_bus.prg_addr  = {r_prg, io_bus.cpu_addr[14:0]};
    assign io_bus.chr_addr  = {r_chr, io_bus.ppu_addr[12:0]};
    assign io_bus.rom_ce    = io_bus.cpu_addr[15];
    assign io_bus.ciram_ce  = ~io_bus.ppu_addr[13];
    assign io_bus.ciram_a10 = i_cfg_mir_v ? io_bus.ppu_addr[10] : io_bus.ppu_addr[11];
endmodule

// File: tb/tb_map_dlatch.sv
// Bench for map_dlatch: three parameterisations (2/4 plain, 2/4 bus-conflict, 1/2 plain) share one stimulus.
// Hand-computed vector table plus a random phase checked against an arithmetic bank model.
module tb_map_dlatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        m2;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic [7:0]  rom_dat;
    logic [13:0] ppu_addr;
    logic        ss_act, ss_we;
    logic [7:0]  ss_addr;
    logic [2:0]  dec_mode;
    logic        mir_v;
    logic [7:0]  map_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    map_dlatch_if #(.PRG_BW(2), .CHR_BW(4)) if_a ();
    map_dlatch_if #(.PRG_BW(2), .CHR_BW(4)) if_b ();
    map_dlatch_if #(.PRG_BW(1), .CHR_BW(2)) if_c ();

    assign if_a.m2 = m2; assign if_a.cpu_addr = cpu_addr; assign if_a.cpu_dat = cpu_dat;
    assign if_a.cpu_rw = cpu_rw; assign if_a.rom_dat = rom_dat; assign if_a.ppu_addr = ppu_addr;
    assign if_a.ss_act = ss_act; assign if_a.ss_we = ss_we; assign if_a.ss_addr = ss_addr;
    assign if_b.m2 = m2; assign if_b.cpu_addr = cpu_addr; assign if_b.cpu_dat = cpu_dat;
    assign if_b.cpu_rw = cpu_rw; assign if_b.rom_dat = rom_dat; assign if_b.ppu_addr = ppu_addr;
    assign if_b.ss_act = ss_act; assign if_b.ss_we = ss_we; assign if_b.ss_addr = ss_addr;
    assign if_c.m2 = m2; assign if_c.cpu_addr = cpu_addr; assign if_c.cpu_dat = cpu_dat;
    assign if_c.cpu_rw = cpu_rw; assign if_c.rom_dat = rom_dat; assign if_c.ppu_addr = ppu_addr;
    assign if_c.ss_act = ss_act; assign if_c.ss_we = ss_we; assign if_c.ss_addr = ss_addr;

    map_dlatch #(.PRG_BW(2), .CHR_BW(4), .BUS_CONF(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_dec_mode(dec_mode), .i_cfg_mir_v(mir_v),
        .i_map_idx(map_idx), .io_bus(if_a));
    map_dlatch #(.PRG_BW(2), .CHR_BW(4), .BUS_CONF(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_dec_mode(dec_mode), .i_cfg_mir_v(mir_v),
        .i_map_idx(map_idx), .io_bus(if_b));
    map_dlatch #(.PRG_BW(1), .CHR_BW(2), .BUS_CONF(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_dec_mode(dec_mode), .i_cfg_mir_v(mir_v),
        .i_map_idx(map_idx), .io_bus(if_c));

    // Reference model: bank state per DUT, derived from the register rules with plain arithmetic.
    int mp[3], mc[3];
    int pbw[3] = '{2, 2, 1};
    int cbw[3] = '{4, 4, 2};
    int bcf[3] = '{0, 1, 0};

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin mp[k] = 0; mc[k] = 0; end
    endtask

    task automatic model_write(input int mode, input int a, input int dat, input int rw, input int rom);
        int m, d, p, c;
        bit hit;
        if (rw != 0) return;
        m = (mode > 4) ? 0 : mode;
        case (m)
            0, 1:    hit = (a >= 32768);
            2:       hit = (a >= 'h7000 && a < 'h8000);
            3:       hit = ((a & 'hE100) == 'h4100);
            default: hit = (a >= 'h6000 && a < 'h8000);
        endcase
        if (!hit) return;
        for (int k = 0; k < 3; k++) begin
            d = (bcf[k] != 0 && a >= 32768) ? (dat & rom) : dat;
            case (m)
                1:       begin p = d % 4;       c = d / 16;                    end
                2:       begin p = d % 4;       c = (d / 4) % 4;               end
                3:       begin p = (d / 8) % 2; c = ((d / 64) % 2) * 8 + d % 8; end
                default: begin p = (d / 16) % 4; c = d % 16;                   end
            endcase
            mp[k] = p % (1 << pbw[k]);
            mc[k] = c % (1 << cbw[k]);
        end
    endtask

    task automatic model_ss_load(input int dat);
        for (int k = 0; k < 3; k++) begin
            mp[k] = (dat / 16) % (1 << pbw[k]);
            mc[k] = (dat % 16) % (1 << cbw[k]);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int prg_of(input int k);
        case (k)
            0:       return int'(if_a.prg_addr[16:15]);
            1:       return int'(if_b.prg_addr[16:15]);
            default: return int'(if_c.prg_addr[15]);
        endcase
    endfunction

    function automatic int chr_of(input int k);
        case (k)
            0:       return int'(if_a.chr_addr[16:13]);
            1:       return int'(if_b.chr_addr[16:13]);
            default: return int'(if_c.chr_addr[14:13]);
        endcase
    endfunction

    task automatic check_model(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_dut%0d_prg", tag, k), prg_of(k), mp[k]);
            check($sformatf("%s_dut%0d_chr", tag, k), chr_of(k), mc[k]);
        end
    endtask

    // One CPU bus cycle: M2 high for 6 clk, then low for 6 clk (enough for the commit to land).
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic [7:0] r);
        @(negedge clk);
        cpu_addr = a; cpu_dat = d; cpu_rw = rw; rom_dat = r; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] addr;
        logic [7:0]  dat;
        logic        rw;
        logic [7:0]  rom;
        int          pa, ca, pb, cb;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int sel, a, mode;
        logic [15:0] ra;
        logic [13:0] pa;

        tbl[0]  = '{3'd0, 16'h8000, 8'h2B, 1'b0, 8'hFF, 2, 'hB, 2, 'hB};
        tbl[1]  = '{3'd0, 16'h8000, 8'h11, 1'b1, 8'hFF, 2, 'hB, 2, 'hB};
        tbl[2]  = '{3'd1, 16'hC000, 8'hF3, 1'b0, 8'h5A, 3, 'hF, 2, 5};
        tbl[3]  = '{3'd3, 16'h4100, 8'h4D, 1'b0, 8'h00, 1, 'hD, 1, 'hD};
        tbl[4]  = '{3'd3, 16'h4000, 8'hFF, 1'b0, 8'hFF, 1, 'hD, 1, 'hD};
        tbl[5]  = '{3'd3, 16'h4200, 8'hFF, 1'b0, 8'hFF, 1, 'hD, 1, 'hD};
        tbl[6]  = '{3'd2, 16'h6FFF, 8'hFF, 1'b0, 8'hFF, 1, 'hD, 1, 'hD};
        tbl[7]  = '{3'd2, 16'h7FFF, 8'h0E, 1'b0, 8'h00, 2, 3, 2, 3};
        tbl[8]  = '{3'd4, 16'h6000, 8'h35, 1'b0, 8'h00, 3, 5, 3, 5};
        tbl[9]  = '{3'd4, 16'h8000, 8'h00, 1'b0, 8'h00, 3, 5, 3, 5};
        tbl[10] = '{3'd7, 16'h8000, 8'h12, 1'b0, 8'hFF, 1, 2, 1, 2};
        tbl[11] = '{3'd0, 16'hFFFF, 8'h3C, 1'b0, 8'h0F, 3, 'hC, 0, 'hC};
        tbl[12] = '{3'd1, 16'h7FFF, 8'hFF, 1'b0, 8'hFF, 3, 'hC, 0, 'hC};
        tbl[13] = '{3'd0, 16'h8000, 8'h3F, 1'b0, 8'hFF, 3, 'hF, 3, 'hF};

        rst = 1'b1; m2 = 1'b0; cpu_addr = '0; cpu_dat = '0; cpu_rw = 1'b1; rom_dat = '0;
        ppu_addr = '0; ss_act = 1'b0; ss_we = 1'b0; ss_addr = 8'd0; dec_mode = 3'd0;
        mir_v = 1'b0; map_idx = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        check("rst_prg", prg_of(0), 0);
        check("rst_chr", chr_of(0), 0);
        check("rst_ss_bank", int'(if_a.ss_rdat), 0);
        check("rst_rom_ce", int'(if_a.rom_ce), 0);
        check("rst_ciram_ce", int'(if_a.ciram_ce), 1);

        // Exact commit latency: unchanged 3 clk after the M2 fall, loaded on the 4th; pend visible in between.
        ss_addr = 8'd1;
        cpu_addr = 16'h8000; cpu_dat = 8'h2B; cpu_rw = 1'b0; rom_dat = 8'hFF; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        check("lat3_prg", prg_of(0), 0);
        check("lat3_chr", chr_of(0), 0);
        check("lat3_pend", int'(if_a.ss_rdat), 1);
        @(negedge clk);
        check("lat4_prg", prg_of(0), 2);
        check("lat4_chr", chr_of(0), 'hB);
        check("lat4_pend", int'(if_a.ss_rdat), 0);
        check("lat4_prg_addr", int'(if_a.prg_addr[16:15]), 2);
        model_write(0, 'h8000, 'h2B, 0, 'hFF);
        ss_addr = 8'd0;
        repeat (4) @(negedge clk);
        check_model("lat");

        // Back-to-back writes on consecutive M2 cycles
        cpu_cycle(16'h8000, 8'h11, 1'b0, 8'hFF);
        check("b2b1_prg", prg_of(0), 1);
        check("b2b1_chr", chr_of(0), 1);
        cpu_cycle(16'h8000, 8'h22, 1'b0, 8'hFF);
        check("b2b2_prg", prg_of(0), 2);
        check("b2b2_chr", chr_of(0), 2);
        model_write(0, 'h8000, 'h11, 0, 'hFF);
        model_write(0, 'h8000, 'h22, 0, 'hFF);

        // Reset between the fall and the commit drops the pending write
        cpu_addr = 16'h8000; cpu_dat = 8'h3F; cpu_rw = 1'b0; rom_dat = 8'hFF; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        check_model("rstpend");

        // Vector table
        for (int i = 0; i < 14; i++) begin
            dec_mode = tbl[i].mode;
            cpu_cycle(tbl[i].addr, tbl[i].dat, tbl[i].rw, tbl[i].rom);
            model_write(int'(tbl[i].mode), int'(tbl[i].addr), int'(tbl[i].dat), int'(tbl[i].rw), int'(tbl[i].rom));
            check($sformatf("tbl%0d_a_prg", i), prg_of(0), tbl[i].pa);
            check($sformatf("tbl%0d_a_chr", i), chr_of(0), tbl[i].ca);
            check($sformatf("tbl%0d_b_prg", i), prg_of(1), tbl[i].pb);
            check($sformatf("tbl%0d_b_chr", i), chr_of(1), tbl[i].cb);
            check($sformatf("tbl%0d_c_prg", i), prg_of(2), mp[2]);
            check($sformatf("tbl%0d_c_chr", i), chr_of(2), mc[2]);
        end

        // Narrow-width truncation: $3F gives prg=1, chr=3 on the 1/2-bit instance
        @(negedge clk);
        cpu_addr = 16'h7FFF;
        #1;
        check("trunc_c_prg", prg_of(2), 1);
        check("trunc_c_chr", chr_of(2), 3);
        check("trunc_c_prg_addr", int'(if_c.prg_addr), 'hFFFF);

        // Save-state write during a CPU write: save state wins
        dec_mode = 3'd1;
        ss_act = 1'b1; ss_we = 1'b1; ss_addr = 8'd0;
        cpu_cycle(16'h8000, 8'h3C, 1'b0, 8'hFF);
        ss_we = 1'b0; ss_act = 1'b0;
        repeat (6) @(negedge clk);
        model_ss_load('h3C);
        check("ss_a_prg", prg_of(0), 3);
        check("ss_a_chr", chr_of(0), 'hC);
        check_model("ss");

        // Save-state reads
        ss_act = 1'b1;
        ss_addr = 8'd0;   #1; check("ssr_bank_a", int'(if_a.ss_rdat), 'h3C);
                              check("ssr_bank_c", int'(if_c.ss_rdat), 'h10);
        ss_addr = 8'd1;   #1; check("ssr_pend", int'(if_a.ss_rdat), 0);
        ss_addr = 8'd127; #1; check("ssr_map", int'(if_a.ss_rdat), 'hA5);
        ss_addr = 8'd5;   #1; check("ssr_other", int'(if_a.ss_rdat), 'hFF);
        ss_act = 1'b0; ss_addr = 8'd0;

        // Combinational address outputs
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra = 16'($urandom); pa = 14'($urandom); mir_v = 1'($urandom);
            cpu_addr = ra; ppu_addr = pa;
            #1;
            check("comb_rom_ce", int'(if_a.rom_ce), (int'(ra) >= 32768) ? 1 : 0);
            check("comb_ciram_ce", int'(if_a.ciram_ce), (int'(pa) < 8192) ? 1 : 0);
            check("comb_a10", int'(if_a.ciram_a10),
                  mir_v ? (int'(pa) / 1024) % 2 : (int'(pa) / 2048) % 2);
            check("comb_prg_addr", int'(if_a.prg_addr), mp[0] * 32768 + int'(ra) % 32768);
            check("comb_chr_addr", int'(if_a.chr_addr), mc[0] * 8192 + int'(pa) % 8192);
        end

        // Random writes against the model
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 7);
            sel  = $urandom_range(0, 4);
            case (sel)
                0:       a = 'h8000 + $urandom_range(0, 'h7FFF);
                1:       a = 'h7000 + $urandom_range(0, 'hFFF);
                2:       a = 'h4100 | ($urandom_range(0, 1) * 'h1000) | $urandom_range(0, 255);
                3:       a = 'h6000 + $urandom_range(0, 'h1FFF);
                default: a = $urandom_range(0, 'hFFFF);
            endcase
            dec_mode = 3'(mode);
            cpu_cycle(16'(a), 8'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
            model_write(mode, a, int'(cpu_dat), int'(cpu_rw), int'(rom_dat));
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
